// File: rtl/rob_pkg.sv
// rob_pkg: shared ROB sizing constants and entry layout
package rob_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_PTR_W = 4;
  localparam int AREG_W = 5;
  localparam int PREG_W = 6;
  localparam int CNT_W = 5;
  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] dr;
    logic [PREG_W-1:0] dr_p;
    logic [PREG_W-1:0] old_p;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// rob_ptr: wrapping ROB pointer with increment enable and parallel load
module rob_ptr
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 ld_i,
  input  logic [ROB_PTR_W-1:0] ld_val_i,
  output logic [ROB_PTR_W-1:0] ptr_o
);
  logic [ROB_PTR_W-1:0] ptr_q, ptr_d;
  // load wins over increment; increment wraps naturally at the pointer width
  always_comb ptr_d = ld_i ? ld_val_i : en_i ? ptr_q + 1'b1 : ptr_q;
  // pointer register
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/rob_retire.sv
// rob_retire: 16-entry reorder buffer with in-order retire; flush port under ROB_FLUSH_EN
module rob_retire
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [AREG_W-1:0] alloc_dr,
  input  logic [PREG_W-1:0] alloc_dr_p,
  input  logic [PREG_W-1:0] alloc_old_p,
  output logic              alloc_ready,
  output logic [ROB_PTR_W-1:0] alloc_rob_num,
  input  logic              cmpl_valid,
  input  logic [ROB_PTR_W-1:0] cmpl_rob_num,
  output logic              ret_valid,
  output logic [AREG_W-1:0] ret_dr,
  output logic [PREG_W-1:0] ret_dr_p,
  output logic [PREG_W-1:0] ret_old_p,
  output logic              ret_free,
  output logic [CNT_W-1:0]  count
`ifdef ROB_FLUSH_EN
  ,
  input  logic              flush
`endif
);
  rob_entry_t ent_q [ROB_DEPTH];
  rob_entry_t ent_d [ROB_DEPTH];
  rob_entry_t hd;
  logic [ROB_PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_q, count_d;
  logic fl, alloc_fire, ret_fire;
  logic ret_valid_q, ret_free_q;
  logic [AREG_W-1:0] ret_dr_q;
  logic [PREG_W-1:0] ret_dr_p_q, ret_old_p_q;
`ifdef ROB_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  assign hd = ent_q[head];
  assign alloc_ready = count_q != CNT_W'(ROB_DEPTH);
  assign alloc_rob_num = tail;
  assign alloc_fire = alloc_valid && alloc_ready && !fl;
  assign ret_fire = hd.valid && hd.done && !fl;
  rob_ptr u_head (.clk(clk), .rst(rst), .en_i(ret_fire), .ld_i(1'b0), .ld_val_i('0), .ptr_o(head));
  rob_ptr u_tail (.clk(clk), .rst(rst), .en_i(alloc_fire), .ld_i(fl), .ld_val_i(head), .ptr_o(tail));
  // entry updates: completion only marks live entries, then retire, then the new allocation
  always_comb begin
    ent_d = ent_q;
    if (cmpl_valid && ent_q[cmpl_rob_num].valid) ent_d[cmpl_rob_num].done = 1'b1;
    if (ret_fire) ent_d[head].valid = 1'b0;
    if (alloc_fire) ent_d[tail] = '{valid: 1'b1, done: alloc_dr == '0, dr: alloc_dr, dr_p: alloc_dr_p, old_p: alloc_old_p};
    if (fl) for (int i = 0; i < ROB_DEPTH; i++) ent_d[i].valid = 1'b0;
  end
  // occupancy counter; a full ROB never allocates so it cannot overflow
  always_comb count_d = fl ? '0 : count_q + CNT_W'(alloc_fire) - CNT_W'(ret_fire);
  // entry storage and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '{default: '0};
      count_q <= '0;
    end else begin
      ent_q <= ent_d;
      count_q <= count_d;
    end
  end
  // retire outputs: valid/free pulse for one cycle, fields hold until the next retire
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_valid_q <= 1'b0;
      ret_free_q <= 1'b0;
      ret_dr_q <= '0;
      ret_dr_p_q <= '0;
      ret_old_p_q <= '0;
    end else begin
      ret_valid_q <= ret_fire;
      ret_free_q <= ret_fire && hd.dr != '0;
      if (ret_fire) begin
        ret_dr_q <= hd.dr;
        ret_dr_p_q <= hd.dr_p;
        ret_old_p_q <= hd.old_p;
      end
    end
  end
  assign ret_valid = ret_valid_q;
  assign ret_free = ret_free_q;
  assign ret_dr = ret_dr_q;
  assign ret_dr_p = ret_dr_p_q;
  assign ret_old_p = ret_old_p_q;
  assign count = count_q;
endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed vector table plus hand-written fill/wrap/flush sequences for rob_retire
module tb_rob_retire;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alloc_valid = 1'b0;
  logic [4:0] alloc_dr = '0;
  logic [5:0] alloc_dr_p = '0, alloc_old_p = '0;
  logic alloc_ready;
  logic [3:0] alloc_rob_num;
  logic cmpl_valid = 1'b0;
  logic [3:0] cmpl_rob_num = '0;
  logic ret_valid, ret_free;
  logic [4:0] ret_dr;
  logic [5:0] ret_dr_p, ret_old_p;
  logic [4:0] count;
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_retire dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dr(alloc_dr), .alloc_dr_p(alloc_dr_p), .alloc_old_p(alloc_old_p),
    .alloc_ready(alloc_ready), .alloc_rob_num(alloc_rob_num),
    .cmpl_valid(cmpl_valid), .cmpl_rob_num(cmpl_rob_num),
    .ret_valid(ret_valid), .ret_dr(ret_dr), .ret_dr_p(ret_dr_p), .ret_old_p(ret_old_p),
    .ret_free(ret_free), .count(count)
`ifdef ROB_FLUSH_EN
    , .flush(flush)
`endif
  );

  typedef struct {
    logic rst, av;
    logic [4:0] dr;
    logic [5:0] drp, old;
    logic cv;
    logic [3:0] cn;
    logic rdy;
    logic [3:0] rnum;
    logic [4:0] cnt;
    logic rv;
    logic [4:0] rdr;
    logic [5:0] rdrp, rold;
    logic rf;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(int r, int av, int dr, int drp, int old, int cv, int cn,
                              int rdy, int rnum, int cnt, int rv, int rdr, int rdrp, int rold, int rf);
    vec_t v;
    v.rst = 1'(r); v.av = 1'(av); v.dr = 5'(dr); v.drp = 6'(drp); v.old = 6'(old);
    v.cv = 1'(cv); v.cn = 4'(cn); v.rdy = 1'(rdy); v.rnum = 4'(rnum); v.cnt = 5'(cnt);
    v.rv = 1'(rv); v.rdr = 5'(rdr); v.rdrp = 6'(rdrp); v.rold = 6'(rold); v.rf = 1'(rf);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic av, logic [4:0] dr, logic [5:0] drp, logic [5:0] old, logic cv, logic [3:0] cn);
    rst = r; alloc_valid = av; alloc_dr = dr; alloc_dr_p = drp; alloc_old_p = old;
    cmpl_valid = cv; cmpl_rob_num = cn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1,0,0,0,0,0,0,  1,0,0,0,0,0,0,0);
    tbl[1]  = mk(0,1,5,33,5,0,0, 1,1,1,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,1,0,  1,1,1,0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,0,  1,1,0,1,5,33,5,1);
    tbl[4]  = mk(0,0,0,0,0,0,0,  1,1,0,0,5,33,5,0);
    tbl[5]  = mk(0,1,1,40,1,0,0, 1,2,1,0,5,33,5,0);
    tbl[6]  = mk(0,1,2,41,2,0,0, 1,3,2,0,5,33,5,0);
    tbl[7]  = mk(0,0,0,0,0,1,2,  1,3,2,0,5,33,5,0);
    tbl[8]  = mk(0,0,0,0,0,0,0,  1,3,2,0,5,33,5,0);
    tbl[9]  = mk(0,0,0,0,0,1,1,  1,3,2,0,5,33,5,0);
    tbl[10] = mk(0,0,0,0,0,0,0,  1,3,1,1,1,40,1,1);
    tbl[11] = mk(0,0,0,0,0,0,0,  1,3,0,1,2,41,2,1);
    tbl[12] = mk(0,0,0,0,0,0,0,  1,3,0,0,2,41,2,0);
    tbl[13] = mk(0,1,0,50,7,0,0, 1,4,1,0,2,41,2,0);
    tbl[14] = mk(0,0,0,0,0,0,0,  1,4,0,1,0,50,7,0);
    tbl[15] = mk(0,0,0,0,0,0,0,  1,4,0,0,0,50,7,0);
    tbl[16] = mk(0,1,3,20,3,1,4, 1,5,1,0,0,50,7,0);
    tbl[17] = mk(0,0,0,0,0,0,0,  1,5,1,0,0,50,7,0);
    tbl[18] = mk(0,0,0,0,0,1,4,  1,5,1,0,0,50,7,0);
    tbl[19] = mk(0,0,0,0,0,0,0,  1,5,0,1,3,20,3,1);
    tbl[20] = mk(0,0,0,0,0,1,9,  1,5,0,0,3,20,3,0);
    tbl[21] = mk(0,1,4,21,4,0,0, 1,6,1,0,3,20,3,0);
    tbl[22] = mk(0,0,0,0,0,1,5,  1,6,1,0,3,20,3,0);
    tbl[23] = mk(1,1,6,22,6,1,5, 1,0,0,0,0,0,0,0);
    tbl[24] = mk(0,0,0,0,0,0,0,  1,0,0,0,0,0,0,0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].dr, tbl[i].drp, tbl[i].old, tbl[i].cv, tbl[i].cn);
      step();
      chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d alloc_rob_num", i), 32'(alloc_rob_num), 32'(tbl[i].rnum));
      chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d ret_valid", i), 32'(ret_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d ret_dr", i), 32'(ret_dr), 32'(tbl[i].rdr));
      chk($sformatf("v%0d ret_dr_p", i), 32'(ret_dr_p), 32'(tbl[i].rdrp));
      chk($sformatf("v%0d ret_old_p", i), 32'(ret_old_p), 32'(tbl[i].rold));
      chk($sformatf("v%0d ret_free", i), 32'(ret_free), 32'(tbl[i].rf));
    end

    // fill all 16 entries without completing any
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 5'(i + 1), 6'(i + 16), 6'(i), 0, 0);
      step();
    end
    chk("full count", 32'(count), 32'd16);
    chk("full alloc_ready", 32'(alloc_ready), 32'd0);
    chk("full tail wrap", 32'(alloc_rob_num), 32'd0);
    drive(0, 1, 20, 20, 20, 0, 0);
    step();
    chk("17th count", 32'(count), 32'd16);
    chk("17th tail", 32'(alloc_rob_num), 32'd0);
    chk("17th ret_valid", 32'(ret_valid), 32'd0);

    // complete head, then retire it while a blocked allocation is presented
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("full cmpl count", 32'(count), 32'd16);
    drive(0, 1, 9, 60, 61, 0, 0);
    step();
    chk("full retire count", 32'(count), 32'd15);
    chk("full retire tail", 32'(alloc_rob_num), 32'd0);
    chk("full retire ready", 32'(alloc_ready), 32'd1);
    chk("full retire valid", 32'(ret_valid), 32'd1);
    chk("full retire dr", 32'(ret_dr), 32'd1);
    chk("full retire dr_p", 32'(ret_dr_p), 32'd16);
    chk("full retire old_p", 32'(ret_old_p), 32'd0);
    chk("full retire free", 32'(ret_free), 32'd1);
    step();
    chk("refill count", 32'(count), 32'd16);
    chk("refill tail", 32'(alloc_rob_num), 32'd1);
    chk("refill ret_valid", 32'(ret_valid), 32'd0);

    // drain in order across the head wrap 15 -> 0
    for (int i = 0; i <= 16; i++) begin
      int k, pk;
      k = (i + 1) % 16;
      pk = i % 16;
      if (i < 16) drive(0, 0, 0, 0, 0, 1, 4'(k));
      else drive(0, 0, 0, 0, 0, 0, 0);
      step();
      if (i >= 1) begin
        chk($sformatf("drain%0d ret_valid", i), 32'(ret_valid), 32'd1);
        chk($sformatf("drain%0d ret_dr_p", i), 32'(ret_dr_p), (pk == 0) ? 32'd60 : 32'(pk + 16));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("drained count", 32'(count), 32'd0);
    chk("drained tail", 32'(alloc_rob_num), 32'd1);
    chk("drained ret_valid", 32'(ret_valid), 32'd0);
    chk("drained ret_dr", 32'(ret_dr), 32'd9);
    chk("drained ret_old_p", 32'(ret_old_p), 32'd61);

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 5'(i + 1), 6'(i + 1), 6'(i + 1), 0, 0);
      step();
    end
    chk("pre-flush count", 32'(count), 32'd5);
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    drive(0, 1, 7, 7, 7, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush count", 32'(count), 32'd0);
    chk("flush tail", 32'(alloc_rob_num), 32'd1);
    chk("flush ret_valid", 32'(ret_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("post-flush ret_valid", 32'(ret_valid), 32'd0);
    drive(0, 1, 8, 8, 8, 0, 0);
    step();
    chk("post-flush tail", 32'(alloc_rob_num), 32'd2);
    chk("post-flush count", 32'(count), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
